// File: rtl/uart_tx_sched_if.sv
// Requester-side bundle for the shared UART TX scheduler: request/ack/done
// handshake plus the serial line and status seen by the requesters.
interface uart_tx_sched_if #(
    parameter int NUM_REQ = 2,
    parameter int OWNER_W = 1
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   ack;
    logic [NUM_REQ-1:0]   done;
    logic [OWNER_W-1:0]   owner;
    logic                 busy;
    logic                 tx;

    modport master (
        output req, req_data,
        input  ack, done, owner, busy, tx
    );

    modport slave (
        input  req, req_data,
        output ack, done, owner, busy, tx
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 UART TX line between NUM_REQ byte
// requesters; the serial frame advances one bit per txclk_en strobe.
module uart_tx_sched #(
    parameter int NUM_REQ = 2,
    parameter int OWNER_W = 1
) (
    input  logic           clk_50m,
    input  logic           rst,
    input  logic           txclk_en,
    uart_tx_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, DATA, STOP} state_t;

    state_t               state_q, state_d;
    logic [7:0]           shift_q, shift_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic                 tx_q, tx_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [NUM_REQ-1:0]   done_q, done_d;

    logic                 grant_found;
    int unsigned          grant_idx;
    int unsigned          scan_idx;

    // Scan starts just after the last winner and wraps; first pending requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 0;
        scan_idx    = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            scan_idx = (32'(rr_ptr_q) + k) % 32'(NUM_REQ);
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!grant_found && i == scan_idx && bus.req[i]) begin
                    grant_found = 1'b1;
                    grant_idx   = i;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        tx_d      = tx_q;
        ack_d     = '0;
        done_d    = '0;
        case (state_q)
            IDLE: begin
                // A strobe coinciding with the grant is deliberately not used.
                if (grant_found) begin
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (i == grant_idx) begin
                            shift_d  = bus.req_data[8*i +: 8];
                            ack_d[i] = 1'b1;
                        end
                    end
                    owner_d  = OWNER_W'(grant_idx);
                    rr_ptr_d = OWNER_W'(grant_idx);
                    state_d  = ARMED;
                end
            end
            ARMED: begin
                if (txclk_en) begin
                    tx_d      = 1'b0;
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (txclk_en) begin
                    tx_d = shift_q[bit_idx_q];
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (txclk_en) begin
                    tx_d = 1'b1;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        if (i == 32'(owner_q)) begin
                            done_d[i] = 1'b1;
                        end
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50m) begin
        if (rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            rr_ptr_q  <= OWNER_W'(NUM_REQ - 1);
            owner_q   <= '0;
            tx_q      <= 1'b1;
            ack_q     <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            rr_ptr_q  <= rr_ptr_d;
            owner_q   <= owner_d;
            tx_q      <= tx_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.done  = done_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q != IDLE);
    assign bus.tx    = tx_q;
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler and bit sequencer that shares one UART TX line between NUM_REQ byte requesters.
- Sits beside the baud rate generator and consumes its txclk_en strobe (one cycle per bit period, 115200 baud at 50 MHz).
- Arbitrates pending requests, latches the winning byte, and emits an 8N1 frame (start, 8 data bits LSB first, stop), one bit per txclk_en.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..8.
- OWNER_W, 1, width of the owner index; must be at least ceil(log2(NUM_REQ)).

Ports:
- clk_50m  input  1  system clock, all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- txclk_en  input  1  bit-period strobe from the baud generator; one cycle wide.
- req  input  NUM_REQ  per-requester send request; level, held until the matching ack.
- req_data  input  8*NUM_REQ  packed bytes; requester i uses bits [8i+7:8i].
- ack  output  NUM_REQ  one-cycle pulse; byte of requester i has been latched.
- done  output  NUM_REQ  one-cycle pulse; the stop bit for requester i's frame has started.
- owner  output  OWNER_W  index of the current or last granted requester.
- busy  output  1  high in any state other than IDLE.
- tx  output  1  serial line, registered, idle high.

Behaviour:
- Reset values: tx=1, ack=0, done=0, busy=0, owner=0, state=IDLE, bit_idx=0, rr_ptr=NUM_REQ-1 (requester 0 has priority first).
- States: IDLE, ARMED, DATA, STOP. State, tx, ack and done are all registered.
- IDLE:
  - Scan req starting at index (rr_ptr+1) mod NUM_REQ, wrapping; the first set bit wins.
  - On a win at edge N: latch that byte into shift_reg, owner<=i, rr_ptr<=i, ack[i]=1 for the cycle after edge N, state<=ARMED.
  - The grant does not wait for txclk_en. No request means stay in IDLE.
- ARMED: on txclk_en, tx<=0 (start bit), bit_idx<=0, state<=DATA. Otherwise hold.
- DATA: on txclk_en, tx<=shift_reg[bit_idx]. If bit_idx==7, state<=STOP; else bit_idx<=bit_idx+1.
- STOP: on txclk_en, tx<=1 (stop bit), done[owner]=1 for one cycle, state<=IDLE.
- Frame timing:
  - Start bit and each data bit last exactly one txclk_en period.
  - The stop bit lasts at least one period, because the next start bit is issued only on a txclk_en in ARMED.
  - Back-to-back frames therefore run at the full 10-bit-per-byte rate.
- Requests:
  - req is sampled only in IDLE. Requests that arrive while busy wait.
  - A req dropped before ack is treated as withdrawn.
  - req_data must be stable while req is high. It is not used after ack.
  - A requester holding req high after its ack is treated as a new request at the next IDLE cycle. With other requesters pending, round-robin denies it back-to-back service.
- txclk_en in the same cycle as a grant in IDLE is ignored for that frame. The start bit goes out on the following txclk_en.
- ack and done are never both high for the same requester in one cycle. At most one ack bit and at most one done bit are high per cycle.
- Reset mid-frame: on the next edge tx=1 and all state returns to reset values. The partial frame is abandoned and no done pulse is issued.
- owner changes only on a grant. It keeps its value through IDLE.

Test Plan:
- Single send: drive txclk_en every 435 cycles; req[0]=1 with byte 0x55.
  - ack[0] pulses once, 1 cycle after req.
  - tx sequence per strobe: 0,1,0,1,0,1,0,1,0,1.
  - done[0] pulses at the stop-bit strobe; busy falls on the same edge.
- Contention: req=2'b11 with bytes 0xA0 and 0x0F held continuously.
  - Grants alternate 0,1,0,1; owner toggles each frame.
  - Frames are back-to-back: 10 strobes each, stop bit exactly one period.
- Rotation: NUM_REQ=4, last owner 2, req=4'b1011 -> next grant is 3, then 0, then 1.
- Grant coincident with txclk_en: req rises so the grant and a strobe share an edge.
  - tx stays 1 through that strobe.
  - The start bit appears at the next strobe.
- Reset mid-frame: assert rst for 1 cycle after the 4th data bit.
  - tx=1 and busy=0 on the next edge; no done pulse.
  - With req[0] still high, rr_ptr has been reset to NUM_REQ-1, so requester 0 is granted again.
- Withdrawn request while busy: req[1] pulses for 50 cycles during requester 0's frame, then drops -> no ack[1], no frame for 1.
